// File: rtl/usr_sequencer.sv
// ---------------------------------------------------------------------------
// usr_sequencer
//
// Command sequencer placed in front of a WIDTH-bit universal shift register.
// It takes one command at a time (hold, shift right N, shift left N, parallel
// load) and drives the register's select lines, serial fill inputs and
// parallel input for exactly the number of clock edges the command needs.
// A shadow copy of the register contents is kept alongside, so a checker can
// compare it against the real register.
//
// Ports:
//   CLK        rising-edge clock, shared with the shift register
//   Clear      asynchronous active-high reset
//   cmd_valid  command present
//   cmd_ready  sequencer can accept a command (IDLE only)
//   cmd_op     00 hold, 01 shift right, 10 shift left, 11 parallel load
//   cmd_count  number of shifts (ignored for ops 00 and 11)
//   cmd_data   parallel load value
//   cmd_fill   serial fill bit for shifts
//   s1, s0     select lines to the shift register
//   MSB_in_o   serial input for shift right
//   LSB_in_o   serial input for shift left
//   I_par_o    parallel input to the shift register
//   busy       a command is in progress
//   done       one-cycle pulse at command completion
//   A_shadow   expected register contents
// ---------------------------------------------------------------------------
module usr_sequencer #(
  parameter int WIDTH = 3,
  parameter int CNT_W = 4
) (
  input  logic             CLK,
  input  logic             Clear,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_fill,
  output logic             s1,
  output logic             s0,
  output logic             MSB_in_o,
  output logic             LSB_in_o,
  output logic [WIDTH-1:0] I_par_o,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] A_shadow
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [1:0]       sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             msb_q, msb_d;
  logic             lsb_q, lsb_d;
  logic [WIDTH-1:0] ipar_q, ipar_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;
  logic [CNT_W-1:0] acceptN;

  // Number of active edges the incoming command needs: the shift count for
  // shifts, a single edge for a load, none for a hold.
  always_comb begin
    acceptN = '0;
    case (cmd_op)
      2'b01, 2'b10: acceptN = cmd_count;
      2'b11:        acceptN = CNT_W'(1);
      default:      acceptN = '0;
    endcase
  end

  // Next-state logic. The selects presented during a RUN cycle are the ones
  // the register acts on at the following edge, so the shadow is updated on
  // that same edge using the latched op and fill bits. The counter stops at
  // 1 -> 0, so the largest count never wraps.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    msb_d    = msb_q;
    lsb_d    = lsb_q;
    ipar_d   = ipar_q;
    shadow_d = shadow_q;
    busy_d   = busy_q;
    done_d   = done_q;
    ready_d  = ready_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          ipar_d  = cmd_data;
          msb_d   = cmd_fill;
          lsb_d   = cmd_fill;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          if (acceptN == '0) begin
            state_d = ST_DONE;
            sel_d   = 2'b00;
            done_d  = 1'b1;
          end else begin
            state_d = ST_RUN;
            sel_d   = cmd_op;
            cnt_d   = acceptN;
          end
        end
      end

      ST_RUN: begin
        case (op_q)
          2'b01:   shadow_d = {msb_q, shadow_q[WIDTH-1:1]};
          2'b10:   shadow_d = {shadow_q[WIDTH-2:0], lsb_q};
          2'b11:   shadow_d = ipar_q;
          default: shadow_d = shadow_q;
        endcase
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          sel_d   = 2'b00;
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end

      ST_DONE: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        sel_d   = 2'b00;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers; Clear aborts any command without a done pulse.
  always_ff @(posedge CLK or posedge Clear) begin
    if (Clear) begin
      state_q  <= ST_IDLE;
      op_q     <= 2'b00;
      sel_q    <= 2'b00;
      cnt_q    <= '0;
      msb_q    <= 1'b0;
      lsb_q    <= 1'b0;
      ipar_q   <= '0;
      shadow_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      msb_q    <= msb_d;
      lsb_q    <= lsb_d;
      ipar_q   <= ipar_d;
      shadow_q <= shadow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
    end
  end

  assign s1        = sel_q[1];
  assign s0        = sel_q[0];
  assign MSB_in_o  = msb_q;
  assign LSB_in_o  = lsb_q;
  assign I_par_o   = ipar_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cmd_ready = ready_q;
  assign A_shadow  = shadow_q;

endmodule

// File: tb/tb_usr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_usr_sequencer
//
// Self-checking bench for usr_sequencer. Commands are driven as directed steps
// plus a randomized batch; expected selects, handshake flags and shadow
// contents come from a small arithmetic model of the shift register.
// ---------------------------------------------------------------------------
module tb_usr_sequencer;

  localparam int WIDTH = 3;
  localparam int CNT_W = 4;

  logic             CLK = 1'b0;
  logic             Clear;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_count;
  logic [WIDTH-1:0] cmd_data;
  logic             cmd_fill;
  logic             s1, s0;
  logic             MSB_in_o, LSB_in_o;
  logic [WIDTH-1:0] I_par_o;
  logic             busy, done;
  logic [WIDTH-1:0] A_shadow;

  int numAsserts = 0;
  int numFails   = 0;
  int modelShadow;

  usr_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .Clear(Clear),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_count(cmd_count), .cmd_data(cmd_data), .cmd_fill(cmd_fill),
    .s1(s1), .s0(s0), .MSB_in_o(MSB_in_o), .LSB_in_o(LSB_in_o),
    .I_par_o(I_par_o), .busy(busy), .done(done), .A_shadow(A_shadow)
  );

  always #5 CLK = ~CLK;

  // Register contents after one edge of the given op, using plain arithmetic.
  function automatic int nextShadow(input int op, input int cur, input int data, input int fill);
    int mask;
    mask = (1 << WIDTH) - 1;
    case (op)
      1:       return (cur >> 1) | (fill << (WIDTH - 1));
      2:       return ((cur << 1) | fill) & mask;
      3:       return data & mask;
      default: return cur;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    numAsserts++;
    assert (obs === exp) else begin
      numFails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag, input int expSel, input int expDone,
                          input int expBusy, input int expReady, input int expShadow);
    checkOutput({tag, ".sel"},    {30'd0, s1, s0}, expSel);
    checkOutput({tag, ".done"},   {31'd0, done}, expDone);
    checkOutput({tag, ".busy"},   {31'd0, busy}, expBusy);
    checkOutput({tag, ".ready"},  {31'd0, cmd_ready}, expReady);
    checkOutput({tag, ".shadow"}, {29'd0, A_shadow}, expShadow);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Issue one command from IDLE and follow it to the return of cmd_ready.
  // With holdValid set, cmd_valid stays high carrying a different command
  // for the whole run, which must be ignored.
  task automatic applyStimulus(input int op, input int count, input int data,
                               input int fill, input bit holdValid);
    int n;
    checkOutput("readyBeforeCmd", {31'd0, cmd_ready}, 1);
    cmd_valid = 1'b1;
    cmd_op    = op[1:0];
    cmd_count = count[CNT_W-1:0];
    cmd_data  = data[WIDTH-1:0];
    cmd_fill  = fill[0];
    n = (op == 1 || op == 2) ? count : (op == 3) ? 1 : 0;
    step();
    if (holdValid) begin
      cmd_op    = ~op[1:0];
      cmd_data  = ~data[WIDTH-1:0];
      cmd_fill  = ~fill[0];
      cmd_count = ~count[CNT_W-1:0];
    end else begin
      cmd_valid = 1'b0;
    end
    if (n == 0) checkAll("e0Hold", 0, 1, 1, 0, modelShadow);
    else        checkAll("e0Run", op, 0, 1, 0, modelShadow);
    checkOutput("iPar",  {29'd0, I_par_o}, data);
    checkOutput("msbIn", {31'd0, MSB_in_o}, fill);
    checkOutput("lsbIn", {31'd0, LSB_in_o}, fill);
    for (int k = 1; k <= n; k++) begin
      step();
      modelShadow = nextShadow(op, modelShadow, data, fill);
      if (k < n) checkAll("runEdge", op, 0, 1, 0, modelShadow);
      else       checkAll("lastEdge", 0, 1, 1, 0, modelShadow);
      checkOutput("iParHeld", {29'd0, I_par_o}, data);
    end
    step();
    checkAll("backIdle", 0, 0, 0, 1, modelShadow);
    cmd_valid = 1'b0;
  endtask

  initial begin
    Clear     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_count = '0;
    cmd_data  = '0;
    cmd_fill  = 1'b0;
    modelShadow = 0;
    #3;
    checkAll("reset", 0, 0, 0, 1, 0);
    checkOutput("resetIPar", {29'd0, I_par_o}, 0);
    checkOutput("resetMsb",  {31'd0, MSB_in_o}, 0);
    checkOutput("resetLsb",  {31'd0, LSB_in_o}, 0);
    step();
    Clear = 1'b0;
    step();

    $display("[TB] load 101");
    applyStimulus(3, 0, 5, 0, 0);
    checkOutput("afterLoad", {29'd0, A_shadow}, 5);

    $display("[TB] shift right 2, fill 1");
    applyStimulus(1, 2, 0, 1, 0);
    checkOutput("afterShr", {29'd0, A_shadow}, 7);

    $display("[TB] shift left 3, fill 0");
    applyStimulus(2, 3, 0, 0, 0);
    checkOutput("afterShl", {29'd0, A_shadow}, 0);

    $display("[TB] zero-count shift and hold");
    applyStimulus(3, 0, 6, 0, 0);
    applyStimulus(1, 0, 1, 1, 0);
    applyStimulus(0, 7, 2, 1, 0);
    checkOutput("afterHold", {29'd0, A_shadow}, 6);

    $display("[TB] cmd_valid held during run");
    applyStimulus(1, 4, 3, 1, 1);

    $display("[TB] maximum count");
    applyStimulus(2, 15, 0, 1, 0);
    checkOutput("afterMax", {29'd0, A_shadow}, 7);

    $display("[TB] clear during a count-5 shift");
    cmd_valid = 1'b1;
    cmd_op    = 2'b10;
    cmd_count = 4'd5;
    cmd_fill  = 1'b0;
    cmd_data  = 3'b010;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    modelShadow = nextShadow(2, nextShadow(2, modelShadow, 0, 0), 0, 0);
    checkAll("midRun", 2, 0, 1, 0, modelShadow);
    #2;
    Clear = 1'b1;
    #1;
    modelShadow = 0;
    checkAll("clearImmediate", 0, 0, 0, 1, 0);
    checkOutput("clearIPar", {29'd0, I_par_o}, 0);
    checkOutput("clearMsb",  {31'd0, MSB_in_o}, 0);
    step();
    Clear = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      checkAll("afterClear", 0, 0, 0, 1, 0);
    end
    applyStimulus(3, 0, 4, 0, 0);

    $display("[TB] randomized commands");
    for (int i = 0; i < 25; i++) begin
      applyStimulus($urandom_range(3, 0), $urandom_range(15, 0),
                    $urandom_range(7, 0), $urandom_range(1, 0),
                    bit'($urandom_range(1, 0)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", numAsserts, numFails);
    $finish;
  end

endmodule
